// File: rtl/hash_pkg.sv
// -----------------------------------------------------------------------------
// hash_pkg
// Shared defaults and types for the hash generator round datapath.
//   DEF_WIDTH  : hash word / key / data width
//   DEF_ROUNDS : rounds applied per hash
//   DEF_CNT_W  : round counter width
//   DEF_ROT    : left-rotate amount of the round function
//   DEF_SHR    : right-shift amount of the feedback term
// -----------------------------------------------------------------------------
package hash_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ROUNDS = 16;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_ROT    = 5;
  localparam int DEF_SHR    = 3;

  // Hash word at the default width.
  typedef logic [DEF_WIDTH-1:0] hash_word_t;

  // Round index at the default counter width.
  typedef logic [DEF_CNT_W-1:0] round_idx_t;

endpackage : hash_pkg

// File: rtl/rnd_mix.sv
// -----------------------------------------------------------------------------
// rnd_mix
// Purely combinational round function:
//   t      = x + key + zero_ext(cnt)   (mod 2^WIDTH)
//   x_next = rotl(t, ROT) ^ (x >> SHR) (logical shift of the old x)
// Ports:
//   x      in  WIDTH : current hash word
//   key    in  WIDTH : round key
//   cnt    in  CNT_W : round index
//   x_next out WIDTH : next hash word
// -----------------------------------------------------------------------------
module rnd_mix
  import hash_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ROT   = DEF_ROT,
  parameter int SHR   = DEF_SHR
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] key,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] x_next
);

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] rot_s;

  // Round function: modular sum, rotate, xor with the shifted old word.
  always_comb begin
    sum_s  = x + key + WIDTH'(cnt);
    // ROT is strictly inside (0, WIDTH), so both shifts are well defined.
    rot_s  = (sum_s << ROT) | (sum_s >> (WIDTH - ROT));
    x_next = rot_s ^ (x >> SHR);
  end

endmodule : rnd_mix

// File: rtl/rnd_datapath.sv
// -----------------------------------------------------------------------------
// rnd_datapath
// Round datapath of the hash generator: holds the working word x and the
// round counter, applying one round per enabled cycle.
// Ports:
//   clk       in  1     : clock, rising edge
//   rst       in  1     : asynchronous active-high reset
//   x_init    in  1     : load din into x (priority over x_en)
//   x_en      in  1     : apply one round to x
//   co_init   in  1     : clear round counter (priority over co_en)
//   co_en     in  1     : advance round counter, wrapping at ROUNDS-1
//   din       in  WIDTH : seed / message word
//   key       in  WIDTH : round key
//   co_co     out 1     : counter is at the last round
//   round_idx out CNT_W : current counter value
//   hash_out  out WIDTH : current x register
// -----------------------------------------------------------------------------
module rnd_datapath
  import hash_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ROT    = DEF_ROT,
  parameter int SHR    = DEF_SHR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_init,
  input  logic             x_en,
  input  logic             co_init,
  input  logic             co_en,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] key,
  output logic             co_co,
  output logic [CNT_W-1:0] round_idx,
  output logic [WIDTH-1:0] hash_out
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

  logic [WIDTH-1:0] x_d;
  logic [WIDTH-1:0] x_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mix_s;
  logic             last_s;

  rnd_mix #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .ROT   (ROT),
    .SHR   (SHR)
  ) u_mix (
    .x      (x_q),
    .key    (key),
    .cnt    (cnt_q),
    .x_next (mix_s)
  );

  // Next-state for the working word and the round counter.
  always_comb begin
    x_d    = x_q;
    cnt_d  = cnt_q;
    last_s = (cnt_q == LAST_IDX);

    if (x_init) begin
      x_d = din;
    end else if (x_en) begin
      x_d = mix_s;
    end else begin
      x_d = x_q;
    end

    // Wrap explicitly at the last round so ROUNDS < 2^CNT_W never reaches ROUNDS.
    if (co_init) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (co_en) begin
      if (last_s) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= {WIDTH{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      x_q   <= x_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs are taken straight from registers; co_co decodes only cnt_q.
  always_comb begin
    hash_out  = x_q;
    round_idx = cnt_q;
    co_co     = (cnt_q == LAST_IDX);
  end

endmodule : rnd_datapath

// File: tb/tb_rnd_datapath.sv
module tb_rnd_datapath;
  import hash_pkg::*;

  localparam int W      = DEF_WIDTH;
  localparam int ROUNDS = DEF_ROUNDS;
  localparam int ROT    = DEF_ROT;
  localparam int SHR    = DEF_SHR;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              x_init = 1'b0;
  logic              x_en = 1'b0;
  logic              co_init = 1'b0;
  logic              co_en = 1'b0;
  hash_word_t        din = '0;
  hash_word_t        key = '0;
  logic              co_co;
  round_idx_t        round_idx;
  hash_word_t        hash_out;

  int checks = 0;
  int errors = 0;

  // Reference state
  hash_word_t m_x;
  int         m_cnt;

  rnd_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .x_init    (x_init),
    .x_en      (x_en),
    .co_init   (co_init),
    .co_en     (co_en),
    .din       (din),
    .key       (key),
    .co_co     (co_co),
    .round_idx (round_idx),
    .hash_out  (hash_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Round function from plain integer arithmetic.
  function automatic hash_word_t ref_mix(input hash_word_t x, input hash_word_t k, input int c);
    longint unsigned modv, xv, kv, t, rot, shr;
    modv = 64'd1 << W;
    xv   = 64'(x);
    kv   = 64'(k);
    t    = (xv + kv + 64'(c)) % modv;
    rot  = ((t * (64'd1 << ROT)) % modv) + (t / (64'd1 << (W - ROT)));
    shr  = xv / (64'd1 << SHR);
    return hash_word_t'(rot) ^ hash_word_t'(shr);
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ":hash"}, 64'(hash_out), 64'(m_x));
    check_val({tag, ":idx"},  64'(round_idx), 64'(m_cnt));
    check_val({tag, ":co"},   64'(co_co), 64'(m_cnt == ROUNDS - 1));
  endtask

  // Apply strobes for one cycle, advance the model, check after the edge.
  task automatic cycle(input logic xi, input logic xe, input logic ci, input logic ce,
                       input hash_word_t d, input hash_word_t k, input string tag);
    hash_word_t nx;
    int         nc;
    x_init = xi; x_en = xe; co_init = ci; co_en = ce; din = d; key = k;
    nx = m_x;
    nc = m_cnt;
    if (xi) nx = d;
    else if (xe) nx = ref_mix(m_x, k, m_cnt);
    if (ci) nc = 0;
    else if (ce) nc = (m_cnt + 1) % ROUNDS;
    @(posedge clk);
    #1;
    m_x = nx;
    m_cnt = nc;
    check_outputs(tag);
  endtask

  task automatic idle();
    x_init = 1'b0; x_en = 1'b0; co_init = 1'b0; co_en = 1'b0;
  endtask

  task automatic golden_run(input string tag);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, {tag, ":init"});
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, {tag, ":r0"});
    check_val({tag, ":g0"}, 64'(hash_out), 64'h0000_0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, {tag, ":r1"});
    check_val({tag, ":g1"}, 64'(hash_out), 64'h0000_0020);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, {tag, ":r2"});
    check_val({tag, ":g2"}, 64'(hash_out), 64'h0000_0444);
  endtask

  initial begin
    hash_word_t seed;
    hash_word_t x_before;
    hash_word_t iter_x;
    int         co_seen;
    int         co_at;

    m_x = '0;
    m_cnt = 0;

    // Reset with active strobes and nonzero din.
    x_init = 1'b1; x_en = 1'b1; co_init = 1'b0; co_en = 1'b1; din = 32'hA5A5_1234;
    rst = 1'b1;
    #1;
    check_outputs("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outputs("rst_hold");
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("rst_release");

    // Init then rounds with zero seed and key.
    golden_run("golden");

    // Full sequence with random seed and keys.
    seed = hash_word_t'($urandom);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, seed, 32'h0, "full:init");
    iter_x = seed;
    co_seen = 0;
    co_at = -1;
    for (int r = 0; r < ROUNDS; r++) begin
      hash_word_t k;
      k = hash_word_t'($urandom);
      if (co_co) begin
        co_seen++;
        co_at = r;
      end
      iter_x = ref_mix(iter_x, k, r);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, k, "full:round");
    end
    idle();
    check_val("full:co_once", 64'(co_seen), 64'd1);
    check_val("full:co_at_16th", 64'(co_at), 64'(ROUNDS - 1));
    check_val("full:idx_wrap", 64'(round_idx), 64'd0);
    check_val("full:hash_iter", 64'(hash_out), 64'(iter_x));

    // Priority of init over enable.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, "prio:x");
    check_val("prio:x_abs", 64'(hash_out), 64'hDEAD_BEEF);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, "prio:cnt");
    check_val("prio:cnt_abs", 64'(round_idx), 64'd0);

    // Hold x while counter advances.
    x_before = hash_out;
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, hash_word_t'($urandom), "hold:cnt_only");
    check_val("hold:x_same", 64'(hash_out), 64'(x_before));
    check_val("hold:idx3", 64'(round_idx), 64'd3);
    // Rounds without counter movement reuse the same cnt.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, hash_word_t'($urandom), "hold:x_only");
    check_val("hold:idx_same", 64'(round_idx), 64'd3);

    // Reset mid-run at round_idx 7.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, hash_word_t'($urandom), 32'h0, "mid:init");
    for (int i = 0; i < 7; i++)
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, hash_word_t'($urandom), "mid:round");
    check_val("mid:at7", 64'(round_idx), 64'd7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_x = '0;
    m_cnt = 0;
    check_outputs("mid:async_clear");
    @(negedge clk);
    idle();
    rst = 1'b0;
    golden_run("mid_golden");

    // Random strobes against the model.
    for (int i = 0; i < 300; i++) begin
      int s;
      s = int'($urandom_range(0, 15));
      cycle(s[0], s[1], s[2], s[3], hash_word_t'($urandom), hash_word_t'($urandom), "rand");
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rnd_datapath
